// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types, constants and helpers for the frequency meter
package freq_meter_pkg;

    // Board clock rate; the default gate window of this many cycles is one second.
    localparam int CLK_HZ = 12000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the gate down-counter: clog2 of the window length, never below 1.
    function automatic int gate_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// rtl/freq_meter_edge_sync.sv - multi-flop synchronizer with rising-edge detector
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the raw input through the chain; keep the last synchronized value for edge detection.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history flops, cleared by reset so no stale edge survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter measuring an asynchronous square wave
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_WIDTH   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig_in,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 count_valid,
    output logic                 overflow
);

    localparam int GW = gate_width(GATE_CYCLES);
    localparam logic [GW-1:0]        GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]        GATE_ONE  = GW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 edge_det;
    state_e               state_q,    state_d;
    logic [GW-1:0]        gate_cnt_q, gate_cnt_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                 ovf_q,      ovf_d;
    logic [CNT_WIDTH-1:0] count_q,    count_d;
    logic                 overflow_q, overflow_d;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(sig_in),
        .rise    (edge_det)
    );

    // Window sequencing, saturating edge count, and capture of the result on window end.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    state_d    = ST_GATE;
                    gate_cnt_d = GATE_LOAD;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_GATE: begin
                if (edge_det) begin
                    if (&edge_cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_ONE;
                    end
                end
                if (gate_cnt_q != '0) begin
                    gate_cnt_d = gate_cnt_q - GATE_ONE;
                end
                // Abort wins over completion; the previous result stays visible.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gate_cnt_q == '0) begin
                    state_d    = ST_DONE;
                    count_d    = edge_cnt_d;
                    overflow_d = ovf_d;
                end
            end
            ST_DONE: begin
                if (continuous) begin
                    state_d    = ST_GATE;
                    gate_cnt_d = GATE_LOAD;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and result registers; reset discards any measurement in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy        = (state_q == ST_GATE);
    assign count_valid = (state_q == ST_DONE);
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter
module tb_freq_meter;

    localparam int GC = 16;
    localparam int CW = 3;
    localparam int SS = 2;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          sig_in     = 1'b0;
    logic          start      = 1'b0;
    logic          continuous = 1'b0;
    logic          abort      = 1'b0;
    logic          busy;
    logic [CW-1:0] count;
    logic          count_valid;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;
    exp_t exp_q[$];

    // Generator control: half period in clk cycles, 0 selects a DC level.
    int   sig_half = 2;
    logic sig_dc   = 1'b0;
    int   gen_ph   = 0;

    freq_meter #(
        .GATE_CYCLES(GC),
        .CNT_WIDTH  (CW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .busy       (busy),
        .count      (count),
        .count_valid(count_valid),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sig_half == 0) begin
                sig_in = sig_dc;
                gen_ph = 0;
            end else begin
                gen_ph = gen_ph + 1;
                if (gen_ph >= sig_half) begin
                    gen_ph = 0;
                    sig_in = ~sig_in;
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start is presented for exactly one sampling edge; returns #1 after that edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advances edge by edge until count_valid is seen or the budget runs out.
    task automatic wait_valid(input int budget, output logic got, output int n,
                              output logic [CW-1:0] c, output logic o);
        got = 1'b0;
        n   = 0;
        c   = '0;
        o   = 1'b0;
        while (!got && n < budget) begin
            @(posedge clk);
            #1;
            n = n + 1;
            if (count_valid === 1'b1) begin
                got = 1'b1;
                c   = count;
                o   = overflow;
            end
        end
    endtask

    task automatic test_reset();
        step(3);
        checks++;
        if ({busy, count_valid, count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b valid=%b count=%0d ovf=%b want all 0",
                     busy, count_valid, count, overflow);
        end
        rst_n = 1'b1;
        step(6);
    endtask

    task automatic test_single();
        exp_t e;
        logic got;
        int   n;
        exp_q.push_back('{cnt: 3'd4, ovf: 1'b0});
        pulse_start();
        for (int i = 1; i <= GC; i++) begin
            checks++;
            if (busy !== 1'b1 || count_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_window cycle %0d got busy=%b valid=%b want 1/0",
                         i, busy, count_valid);
            end
            step(1);
        end
        checks++;
        if (busy !== 1'b0 || count_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_done got busy=%b valid=%b want 0/1", busy, count_valid);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (count !== e.cnt || overflow !== e.ovf) begin
                errors++;
                $display("FAIL single_result got %0d/%b want %0d/%b", count, overflow, e.cnt, e.ovf);
            end
        end
        step(1);
        checks++;
        if (count_valid !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL single_hold got valid=%b count=%0d want 0/4", count_valid, count);
        end
        got = 1'b0;
        n   = 0;
    endtask

    task automatic test_overflow();
        exp_t          e;
        logic          got;
        int            n;
        logic [CW-1:0] c;
        logic          o;
        sig_half = 1;
        step(6);
        exp_q.push_back('{cnt: 3'd7, ovf: 1'b1});
        pulse_start();
        wait_valid(GC + 8, got, n, c, o);
        e = exp_q.pop_front();
        checks++;
        if (!got || n != GC || c !== e.cnt || o !== e.ovf) begin
            errors++;
            $display("FAIL overflow_result got=%b lat=%0d %0d/%b want lat=%0d %0d/%b",
                     got, n, c, o, GC, e.cnt, e.ovf);
        end
        sig_half = 2;
        step(6);
        exp_q.push_back('{cnt: 3'd4, ovf: 1'b0});
        pulse_start();
        wait_valid(GC + 8, got, n, c, o);
        e = exp_q.pop_front();
        checks++;
        if (!got || c !== e.cnt || o !== e.ovf) begin
            errors++;
            $display("FAIL overflow_clear got=%b %0d/%b want %0d/%b", got, c, o, e.cnt, e.ovf);
        end
    endtask

    task automatic test_continuous();
        exp_t          e;
        logic          got;
        int            n;
        logic [CW-1:0] c;
        logic          o;
        sig_half = 2;
        step(2);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{cnt: 3'd4, ovf: 1'b0});
        end
        continuous = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(GC + 8, got, n, c, o);
            e = exp_q.pop_front();
            checks++;
            if (!got || n != GC + 1 || c !== e.cnt || o !== e.ovf) begin
                errors++;
                $display("FAIL continuous_%0d got=%b period=%0d %0d/%b want period=%0d %0d/%b",
                         k, got, n, c, o, GC + 1, e.cnt, e.ovf);
            end
        end
        step(8);
        continuous = 1'b0;
        wait_valid(GC + 8, got, n, c, o);
        e = exp_q.pop_front();
        checks++;
        if (!got || n != GC + 1 - 8 || c !== e.cnt || o !== e.ovf) begin
            errors++;
            $display("FAIL continuous_last got=%b lat=%0d %0d/%b want lat=%0d %0d/%b",
                     got, n, c, o, GC + 1 - 8, e.cnt, e.ovf);
        end
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (busy !== 1'b0 || count_valid !== 1'b0) begin
                errors++;
                $display("FAIL continuous_stop cycle %0d got busy=%b valid=%b want 0/0",
                         i, busy, count_valid);
            end
        end
    endtask

    task automatic test_abort();
        exp_t          e;
        logic          got;
        int            n;
        logic [CW-1:0] c;
        logic          o;
        sig_half = 1;
        step(6);
        exp_q.push_back('{cnt: 3'd7, ovf: 1'b1});
        pulse_start();
        wait_valid(GC + 8, got, n, c, o);
        e = exp_q.pop_front();
        checks++;
        if (!got || c !== e.cnt || o !== e.ovf) begin
            errors++;
            $display("FAIL abort_setup got=%b %0d/%b want %0d/%b", got, c, o, e.cnt, e.ovf);
        end
        sig_half = 2;
        step(6);
        pulse_start();
        step(7);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b want 0", busy);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (count_valid !== 1'b0 || count !== e.cnt || overflow !== e.ovf) begin
                errors++;
                $display("FAIL abort_hold cycle %0d got valid=%b %0d/%b want 0 %0d/%b",
                         i, count_valid, count, overflow, e.cnt, e.ovf);
            end
            step(1);
        end
        exp_q.push_back('{cnt: 3'd4, ovf: 1'b0});
        pulse_start();
        for (int i = 1; i <= GC; i++) begin
            checks++;
            if (busy !== 1'b1 || count_valid !== 1'b0) begin
                errors++;
                $display("FAIL restart_window cycle %0d got busy=%b valid=%b want 1/0",
                         i, busy, count_valid);
            end
            start = (i == 5);
            step(1);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (count_valid !== 1'b1 || count !== e.cnt || overflow !== e.ovf) begin
            errors++;
            $display("FAIL restart_result got valid=%b %0d/%b want 1 %0d/%b",
                     count_valid, count, overflow, e.cnt, e.ovf);
        end
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (count_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL restart_extra cycle %0d got busy=%b valid=%b want 0/0",
                         i, busy, count_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t          e;
        logic          got;
        int            n;
        logic [CW-1:0] c;
        logic          o;
        pulse_start();
        step(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, count_valid, count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b valid=%b count=%0d ovf=%b want all 0",
                     busy, count_valid, count, overflow);
        end
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < GC + 4; i++) begin
            step(1);
            checks++;
            if (count_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got busy=%b valid=%b want 0/0",
                         i, busy, count_valid);
            end
        end
        exp_q.push_back('{cnt: 3'd4, ovf: 1'b0});
        pulse_start();
        wait_valid(GC + 8, got, n, c, o);
        e = exp_q.pop_front();
        checks++;
        if (!got || n != GC || c !== e.cnt || o !== e.ovf) begin
            errors++;
            $display("FAIL reset_after got=%b lat=%0d %0d/%b want lat=%0d %0d/%b",
                     got, n, c, o, GC, e.cnt, e.ovf);
        end
    endtask

    task automatic test_dc();
        exp_t          e;
        logic          got;
        int            n;
        logic [CW-1:0] c;
        logic          o;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            sig_dc   = lvl[0];
            sig_half = 0;
            step(6);
            exp_q.push_back('{cnt: 3'd0, ovf: 1'b0});
            pulse_start();
            wait_valid(GC + 8, got, n, c, o);
            e = exp_q.pop_front();
            checks++;
            if (!got || n != GC || c !== e.cnt || o !== e.ovf) begin
                errors++;
                $display("FAIL dc_%0d got=%b lat=%0d %0d/%b want lat=%0d %0d/%b",
                         lvl, got, n, c, o, GC, e.cnt, e.ovf);
            end
            for (int i = 0; i < 6; i++) begin
                step(1);
                checks++;
                if (count_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL dc_single_%0d cycle %0d got valid=%b want 0", lvl, i, count_valid);
                end
            end
        end
        sig_half = 2;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_continuous();
        test_abort();
        test_reset_mid();
        test_dc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
